// File: rtl/mem_bus_ctrl_pkg.sv
// Shared typedefs and defaults for the CPU memory-bus controller.
package mem_bus_ctrl_pkg;

   localparam int unsigned MBUS_AW      = 5;
   localparam int unsigned MBUS_DW      = 8;
   localparam int unsigned MBUS_TIMEOUT = 15;

   // Literals carry an MB_ prefix so they never clash with the controller's state_t.
   typedef enum logic [1:0] {
      MB_IDLE = 2'd0,
      MB_REQ  = 2'd1,
      MB_DONE = 2'd2,
      MB_HOLD = 2'd3
   } mbus_state_t;

   // Width of a counter that must be able to hold the value `timeout`.
   function automatic int unsigned mbus_cnt_w(input int unsigned timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_timer.sv
// Bus wait counter: counts no-ack REQ cycles and flags the last allowed wait cycle.
module mem_bus_ctrl_timer
   import mem_bus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = MBUS_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_limit_o
);

   localparam int unsigned CntW = mbus_cnt_w(TIMEOUT);
   localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // A no-ack cycle seen while the count sits here is the TIMEOUT-th wait.
   assign at_limit_o = (cnt_q == LastWait);

   // Next count: clear outside REQ, otherwise advance on every unacknowledged cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: turns each mem_rd/mem_wr strobe window into one req/ack
// transaction, stalls the CPU controller meanwhile, and guards the bus with a timeout.
// Optional: define MBUS_PERF_CNT_EN to add the saturating stall_cnt output.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int unsigned AW      = MBUS_AW,
   parameter int unsigned DW      = MBUS_DW,
   parameter int unsigned TIMEOUT = MBUS_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_rd,
   input  logic          mem_wr,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          rdata_valid,
   output logic          stall,
   output logic          err,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_ack,
   input  logic [DW-1:0] bus_rdata
`ifdef MBUS_PERF_CNT_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   mbus_state_t   state_q, state_d;
   logic          bus_we_q, bus_we_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          rdata_valid_q, rdata_valid_d;
   logic          err_q, err_d;
   logic          strobe;
   logic          tmr_clr, tmr_inc, tmr_at_limit;

   assign strobe  = mem_rd | mem_wr;
   assign tmr_clr = (state_q != MB_REQ);
   assign tmr_inc = (state_q == MB_REQ) && !bus_ack;

   mem_bus_ctrl_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (tmr_clr),
      .inc_i      (tmr_inc),
      .at_limit_o (tmr_at_limit)
   );

   // Next-state and output decode; every target gets a default first.
   always_comb begin
      state_d       = state_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      err_d         = err_q;
      stall         = 1'b0;
      bus_req       = 1'b0;
      unique case (state_q)
         MB_IDLE: begin
            if (strobe) begin
               // Freeze the controller in the same cycle the strobe appears.
               stall       = 1'b1;
               bus_addr_d  = addr;
               bus_wdata_d = wdata;
               bus_we_d    = mem_wr;
               if (mem_rd && mem_wr) begin
                  err_d = 1'b1;
               end
               state_d = MB_REQ;
            end
         end
         MB_REQ: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            if (bus_ack) begin
               if (!bus_we_q) begin
                  rdata_d       = bus_rdata;
                  rdata_valid_d = 1'b1;
               end
               state_d = MB_DONE;
            end else if (tmr_at_limit) begin
               err_d   = 1'b1;
               state_d = MB_DONE;
            end
         end
         MB_DONE: begin
            // Strobe still high means the controller is mid-window: wait it out.
            state_d = strobe ? MB_HOLD : MB_IDLE;
         end
         MB_HOLD: begin
            if (!strobe) begin
               state_d = MB_IDLE;
            end
         end
         default: state_d = MB_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= MB_IDLE;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_wdata_q   <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         err_q         <= err_d;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign err         = err_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_wdata   = bus_wdata_q;

`ifdef MBUS_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of stalled cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Stall counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a driver issues strobe windows and pushes the
// expected bus transaction and read data; a monitor pops and compares whenever the
// DUT raises bus_req or rdata_valid.
module tb_mem_bus_ctrl;

   localparam int unsigned AW      = 5;
   localparam int unsigned DW      = 8;
   localparam int unsigned TIMEOUT = 15;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_rd, mem_wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          rdata_valid, stall, err;
   logic          bus_req, bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_ack = 1'b0;
   logic [DW-1:0] bus_rdata = '0;
`ifdef MBUS_PERF_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int            checks = 0;
   int            errors = 0;

   // Reference model state
   txn_t          txn_q[$];
   logic [DW-1:0] rd_q[$];
   logic          err_exp = 1'b0;
   logic [DW-1:0] last_rdata = '0;
   int            perf_exp = 0;
   int            cur_wait = 0;
   logic [DW-1:0] cur_rdata = '0;

   mem_bus_ctrl #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_rd      (mem_rd),
      .mem_wr      (mem_wr),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .stall       (stall),
      .err         (err),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata)
`ifdef MBUS_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus responder: acks after cur_wait wait cycles; random ack noise while idle.
   int resp_cnt = 0;
   always @(negedge clk) begin
      if (bus_req === 1'b1) begin
         bus_ack   = (resp_cnt == cur_wait);
         bus_rdata = (resp_cnt == cur_wait) ? cur_rdata : DW'($urandom);
         resp_cnt++;
      end else begin
         resp_cnt  = 0;
         bus_ack   = ($urandom_range(0, 3) == 0);
         bus_rdata = DW'($urandom);
      end
   end

   // Monitor: pop expected transaction on each bus_req rise, expected data on rdata_valid.
   txn_t          cur_txn = '0;
   logic          req_prev = 1'b0;
   logic [DW-1:0] exp_rd;
   always @(negedge clk) begin
      if (bus_req === 1'b1) begin
         if (!req_prev) begin
            chk("req_expected", 32'(txn_q.size() > 0), 1);
            if (txn_q.size() > 0) cur_txn = txn_q.pop_front();
         end
         chk("bus_we", 32'(bus_we), 32'(cur_txn.we));
         chk("bus_addr", 32'(bus_addr), 32'(cur_txn.addr));
         chk("bus_wdata", 32'(bus_wdata), 32'(cur_txn.data));
      end
      if (rdata_valid === 1'b1) begin
         chk("rv_after_req", 32'(req_prev), 1);
         chk("rv_expected", 32'(rd_q.size() > 0), 1);
         if (rd_q.size() > 0) begin
            exp_rd = rd_q.pop_front();
            chk("rdata", 32'(rdata), 32'(exp_rd));
         end
      end
      req_prev = (bus_req === 1'b1);
   end

   // One strobe window: w wait states before ack (w >= TIMEOUT means no ack),
   // strobe held `hold` extra cycles after stall releases, then `gap` idle cycles.
   task automatic window(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int w, input logic [DW-1:0] rdat,
                         input int hold, input int gap);
      logic completes;
      int   exp_stall;
      int   stalls = 0;
      int   budget = 0;
      completes = (w < TIMEOUT);
      exp_stall = 1 + (completes ? w + 1 : TIMEOUT);
      @(posedge clk);
      #1;
      cur_wait  = w;
      cur_rdata = rdat;
      txn_q.push_back('{we: wr, addr: a, data: d});
      if (rd && !wr && completes) begin
         rd_q.push_back(rdat);
         last_rdata = rdat;
      end
      if ((rd && wr) || !completes) err_exp = 1'b1;
      perf_exp += exp_stall;
      mem_rd = rd;
      mem_wr = wr;
      addr   = a;
      wdata  = d;
      @(negedge clk);
      while (stall === 1'b1 && budget < 100) begin
         stalls++;
         budget++;
         @(posedge clk);
         #1;
         // Address/data wander inside the window must not matter.
         addr  = AW'($urandom);
         wdata = DW'($urandom);
         @(negedge clk);
      end
      chk("stall_cycles", 32'(stalls), 32'(exp_stall));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_quiet", {30'd0, bus_req, stall}, 0);
      end
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      for (int i = 0; i < gap; i++) @(negedge clk);
      chk("gap_stall", 32'(stall), 0);
      chk("err", 32'(err), 32'(err_exp));
      chk("rdata_hold", 32'(rdata), 32'(last_rdata));
`ifdef MBUS_PERF_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(perf_exp));
`endif
   endtask

   // Reset lands in the second REQ cycle; the in-flight read must vanish.
   task automatic reset_in_flight();
      @(posedge clk);
      #1;
      cur_wait = 1000;
      mem_rd   = 1'b1;
      mem_wr   = 1'b0;
      addr     = 5'h07;
      wdata    = 8'h11;
      txn_q.push_back('{we: 1'b0, addr: 5'h07, data: 8'h11});
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("req_before_rst", 32'(bus_req), 1);
      rst    = 1'b1;
      mem_rd = 1'b0;
      @(posedge clk);
      #1;
      err_exp    = 1'b0;
      last_rdata = '0;
      perf_exp   = 0;
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_rv", 32'(rdata_valid), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rdata", 32'(rdata), 0);
`ifdef MBUS_PERF_CNT_EN
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic rd, wr;
      int   kind, w;
      rst    = 1'b1;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      addr   = '0;
      wdata  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_bus_req", 32'(bus_req), 0);
      chk("reset_bus_we", 32'(bus_we), 0);
      chk("reset_stall", 32'(stall), 0);
      chk("reset_err", 32'(err), 0);
      chk("reset_rdata", 32'(rdata), 0);
      chk("reset_rv", 32'(rdata_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Zero-wait read, 3-wait write, held read window, last-chance ack.
      window(1'b1, 1'b0, 5'h0A, 8'h00, 0, 8'h3C, 0, 1);
      window(1'b0, 1'b1, 5'h1F, 8'hA5, 3, 8'h00, 0, 1);
      window(1'b1, 1'b0, 5'h04, 8'h00, 0, 8'h5A, 2, 1);
      window(1'b1, 1'b0, 5'h05, 8'h00, 0, 8'h66, 0, 2);
      window(1'b1, 1'b0, 5'h06, 8'h00, TIMEOUT - 1, 8'hC3, 0, 1);
      // Timeout, then a both-strobe write; err must stay set.
      window(1'b1, 1'b0, 5'h08, 8'h00, TIMEOUT, 8'hEE, 0, 1);
      window(1'b1, 1'b1, 5'h02, 8'h77, 1, 8'h00, 1, 1);
      window(1'b1, 1'b0, 5'h09, 8'h00, 2, 8'h81, 0, 1);
      reset_in_flight();
      window(1'b1, 1'b0, 5'h0B, 8'h00, 0, 8'h42, 0, 1);

      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 9));
         rd   = (kind <= 4) || (kind == 9);
         wr   = (kind >= 5);
         w    = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 4));
         window(rd, wr, AW'($urandom), DW'($urandom), w, DW'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
      end

      @(negedge clk);
      chk("txn_q_drained", 32'(txn_q.size()), 0);
      chk("rd_q_drained", 32'(rd_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
